// File: rtl/seq_detect_pkg.sv
// Shared definitions for the serial pattern detector controller:
// controller states, default sizing and the pattern length mask helper.
package seq_detect_pkg;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_LEN_W   = 4;
  localparam int DEF_CNT_W   = 8;

  // Controller states. The state register is exported for observation.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // One bit of the length mask: position idx takes part in the compare
  // when it lies inside the programmed pattern length.
  function automatic logic len_mask_bit(input int unsigned idx, input int unsigned len);
    return (idx < len);
  endfunction

endpackage

// File: rtl/seq_window_match.sv
// Sliding window over the serial input: a MAX_LEN-bit history with a
// saturating count of valid bits, and a masked compare against the pattern.
// The hit output is evaluated on the post-shift view of the window so the
// controller can react to a match on the same edge the bit is sampled.
module seq_window_match
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = DEF_LEN_W
) (
  input  logic               clk,
  input  logic               R,
  input  logic               shift_en,
  input  logic               clr,
  input  logic               clr_cnt,
  input  logic               in,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               hit
);

  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_cnt;

  logic [MAX_LEN-1:0] w_hist_next;
  logic [LEN_W-1:0]   w_cnt_next;
  logic [MAX_LEN-1:0] w_mask;

  // Next history and saturating bit count, as they would be after this edge.
  always_comb begin
    w_hist_next = {r_hist[MAX_LEN-2:0], in};
    w_cnt_next  = (r_cnt >= LEN_W'(MAX_LEN)) ? r_cnt : (r_cnt + LEN_W'(1));
  end

  // Build the compare mask covering the low len bits.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = len_mask_bit(unsigned'(i), 32'(len));
    end
  end

  // Match when enough bits have arrived and every masked bit agrees.
  always_comb begin
    hit = shift_en && (w_cnt_next >= len) &&
          (((w_hist_next ^ pattern) & w_mask) == '0);
  end

  // History and count update; clr wins over shifting, clr_cnt restarts
  // the count on a non-overlapping match while the history still shifts.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      r_hist <= '0;
      r_cnt  <= '0;
    end else if (clr) begin
      r_hist <= '0;
      r_cnt  <= '0;
    end else if (shift_en) begin
      r_hist <= w_hist_next;
      r_cnt  <= clr_cnt ? '0 : w_cnt_next;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Programmable serial pattern detector controller.
// Handshake: a configuration transfers on a rising edge where cfg_valid and
// cfg_ready are both high; cfg_ready is high only in IDLE, and cfg_valid
// in any other state is simply ignored (nothing is queued).
// Flow: IDLE -> (legal config) ARMED -> (start) RUN -> (target reached) DONE -> IDLE.
// abort returns ARMED or RUN to IDLE and takes priority over start.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               R,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic               start,
  input  logic               abort,
  input  logic               in,
  output logic               out,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [CNT_W-1:0]   match_cnt,
  output state_t             dbg_state
);

  state_t             r_state;
  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  logic [CNT_W-1:0]   r_target;
  logic [CNT_W-1:0]   r_match_cnt;
  logic               r_out;
  logic               r_done;
  logic               r_err;

  logic               w_cfg_legal;
  logic               w_shift_en;
  logic               w_clr;
  logic               w_clr_cnt;
  logic               w_hit;
  logic [CNT_W-1:0]   w_cnt_inc;

  // Window control derived from the current state and the command inputs.
  always_comb begin
    w_cfg_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    w_shift_en  = (r_state == S_RUN) && !abort;
    w_clr       = (r_state == S_ARMED) && start && !abort;
    w_clr_cnt   = w_shift_en && w_hit && !r_overlap;
    w_cnt_inc   = r_match_cnt + CNT_W'(1);
  end

  seq_window_match #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_window (
    .clk      (clk),
    .R        (R),
    .shift_en (w_shift_en),
    .clr      (w_clr),
    .clr_cnt  (w_clr_cnt),
    .in       (in),
    .pattern  (r_pattern),
    .len      (r_len),
    .hit      (w_hit)
  );

  // Controller FSM with stored configuration, match counter and the
  // registered out/done/err pulses.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      r_state     <= S_IDLE;
      r_pattern   <= '0;
      r_len       <= '0;
      r_overlap   <= 1'b0;
      r_target    <= '0;
      r_match_cnt <= '0;
      r_out       <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_out  <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cfg_valid) begin
            if (w_cfg_legal) begin
              r_pattern <= cfg_pattern;
              r_len     <= cfg_len;
              r_overlap <= cfg_overlap;
              r_target  <= cfg_target;
              r_state   <= S_ARMED;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_ARMED: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else if (start) begin
            r_match_cnt <= '0;
            r_state     <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else if (w_hit) begin
            r_out       <= 1'b1;
            r_match_cnt <= w_cnt_inc;
            if ((r_target != '0) && (w_cnt_inc == r_target)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cfg_ready = (r_state == S_IDLE);
  assign busy      = (r_state == S_ARMED) || (r_state == S_RUN);
  assign out       = r_out;
  assign done      = r_done;
  assign err       = r_err;
  assign match_cnt = r_match_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: directed scenarios plus randomized runs.
// The driver pushes expected out/done/err events (with the cycle they must
// appear in and the match count shown then) into exp_q; a monitor pops and
// compares whenever the DUT raises one of those flags.
module tb_seq_detect_ctrl;
  import seq_detect_pkg::*;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 8;
  localparam int EW      = 26;  // {cycle[15:0], kind[1:0], match_cnt[7:0]}

  localparam logic [1:0] K_OUT  = 2'd1;
  localparam logic [1:0] K_DONE = 2'd2;
  localparam logic [1:0] K_ERR  = 2'd3;

  logic               clk = 1'b0;
  logic               R;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic [CNT_W-1:0]   cfg_target;
  logic               start;
  logic               abort;
  logic               din;
  logic               dout;
  logic               busy;
  logic               done;
  logic               err;
  logic [CNT_W-1:0]   match_cnt;
  state_t             dbg_state;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  logic [EW-1:0] exp_q[$];
  logic          stim_q[$];

  // Reference model state
  logic          m_hist[$];
  logic [7:0]    m_pat;
  int            m_len;
  logic          m_ov;
  logic [7:0]    m_tgt;
  logic [7:0]    m_cnt = 8'd0;

  seq_detect_ctrl #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .R           (R),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_target  (cfg_target),
    .start       (start),
    .abort       (abort),
    .in          (din),
    .out         (dout),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .match_cnt   (match_cnt),
    .dbg_state   (dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [EW-1:0] mk_ev(input int c, input logic [1:0] k, input logic [7:0] n);
    logic [31:0] cv;
    cv = c;
    return {cv[15:0], k, n};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic pop_cmp(input logic [1:0] kind, input string name);
    logic [EW-1:0] act;
    logic [EW-1:0] req;
    act = mk_ev(cyc, kind, match_cnt);
    if (exp_q.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s_unexpected: got event %0h, expected none (cycle %0d)", name, act, cyc);
    end else begin
      req = exp_q.pop_front();
      chk(name, 32'(act), 32'(req));
    end
  endtask

  // Monitor: sample just after each rising edge, in the order out, done, err.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (dout === 1'b1) pop_cmp(K_OUT, "out_event");
      if (done === 1'b1) pop_cmp(K_DONE, "done_event");
      if (err === 1'b1)  pop_cmp(K_ERR, "err_event");
    end
  end

  // Reference model: one received bit; returns fin when the target is reached.
  task automatic model_bit(input logic b, output bit fin);
    bit hit;
    int sz;
    fin = 1'b0;
    m_hist.push_back(b);
    if (m_hist.size() > MAX_LEN) void'(m_hist.pop_front());
    sz  = m_hist.size();
    hit = (sz >= m_len);
    if (hit) begin
      for (int k = 0; k < m_len; k++) begin
        if (m_hist[sz - 1 - k] != m_pat[k]) hit = 1'b0;
      end
    end
    if (hit) begin
      m_cnt = m_cnt + 8'd1;
      exp_q.push_back(mk_ev(cyc + 1, K_OUT, m_cnt));
      if (!m_ov) m_hist.delete();
      if ((m_tgt != 8'd0) && (m_cnt == m_tgt)) begin
        exp_q.push_back(mk_ev(cyc + 1, K_DONE, m_cnt));
        fin = 1'b1;
      end
    end
  endtask

  // Driver tasks: each starts and ends just after a falling edge.
  task automatic cfg_ok(input logic [7:0] p, input int l, input logic o, input logic [7:0] t);
    chk("cfg_ready_idle", 32'(cfg_ready), 32'd1);
    cfg_valid   = 1'b1;
    cfg_pattern = p;
    cfg_len     = LEN_W'(l);
    cfg_overlap = o;
    cfg_target  = t;
    m_pat = p;
    m_len = l;
    m_ov  = o;
    m_tgt = t;
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("busy_armed", 32'(busy), 32'd1);
    chk("cfg_ready_armed", 32'(cfg_ready), 32'd0);
  endtask

  task automatic cfg_bad(input int l);
    chk("cfg_ready_before_bad", 32'(cfg_ready), 32'd1);
    cfg_valid   = 1'b1;
    cfg_len     = LEN_W'(l);
    cfg_pattern = MAX_LEN'($urandom);
    exp_q.push_back(mk_ev(cyc + 1, K_ERR, m_cnt));
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("busy_after_bad", 32'(busy), 32'd0);
    chk("cfg_ready_after_bad", 32'(cfg_ready), 32'd1);
  endtask

  // start, with a junk configuration offered at the same time (must be ignored)
  task automatic do_start();
    chk("cfg_ready_before_start", 32'(cfg_ready), 32'd0);
    start       = 1'b1;
    cfg_valid   = 1'b1;
    cfg_pattern = MAX_LEN'($urandom);
    cfg_len     = LEN_W'($urandom_range(0, 15));
    cfg_overlap = 1'($urandom_range(0, 1));
    cfg_target  = CNT_W'($urandom_range(1, 3));
    @(negedge clk);
    start     = 1'b0;
    cfg_valid = 1'b0;
    m_hist.delete();
    m_cnt = 8'd0;
    chk("match_cnt_after_start", 32'(match_cnt), 32'd0);
    chk("busy_run", 32'(busy), 32'd1);
  endtask

  // Feed stim_q; finish either through the target or with an abort.
  task automatic feed(input string tag);
    bit fin;
    fin = 1'b0;
    foreach (stim_q[i]) begin
      din = stim_q[i];
      model_bit(stim_q[i], fin);
      @(negedge clk);
      if (fin) break;
    end
    if (fin) begin
      chk({tag, "_busy_done"}, 32'(busy), 32'd0);
      @(negedge clk);
      chk({tag, "_cfg_ready_after_done"}, 32'(cfg_ready), 32'd1);
    end else begin
      abort = 1'b1;
      din   = 1'($urandom_range(0, 1));
      @(negedge clk);
      abort = 1'b0;
      chk({tag, "_busy_after_abort"}, 32'(busy), 32'd0);
      chk({tag, "_cfg_ready_after_abort"}, 32'(cfg_ready), 32'd1);
    end
    chk({tag, "_match_cnt_final"}, 32'(match_cnt), 32'(m_cnt));
    chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic run(input string tag, input logic [7:0] p, input int l, input logic o,
                     input logic [7:0] t);
    cfg_ok(p, l, o, t);
    do_start();
    feed(tag);
  endtask

  task automatic load_bits(input logic [31:0] bits, input int n);
    stim_q.delete();
    for (int i = n - 1; i >= 0; i--) stim_q.push_back(bits[i]);
  endtask

  initial begin
    bit fin;
    logic [7:0] p;
    int l;

    R           = 1'b0;
    cfg_valid   = 1'b0;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_overlap = 1'b0;
    cfg_target  = '0;
    start       = 1'b0;
    abort       = 1'b0;
    din         = 1'b0;

    // Reset state
    @(posedge clk);
    #2;
    chk("rst_out", 32'(dout), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_match_cnt", 32'(match_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    R = 1'b1;
    @(negedge clk);

    // 101, overlapping, free running: two matches
    load_bits(32'b10101, 5);
    run("ovl", 8'b101, 3, 1'b1, 8'd0);
    chk("ovl_cnt_is_2", 32'(match_cnt), 32'd2);

    // Same stream, non-overlapping: one match
    load_bits(32'b10101, 5);
    run("novl", 8'b101, 3, 1'b0, 8'd0);
    chk("novl_cnt_is_1", 32'(match_cnt), 32'd1);

    // Target 2: done after bit 5, count held
    load_bits(32'b10101, 5);
    run("tgt2", 8'b101, 3, 1'b1, 8'd2);
    chk("tgt2_cnt_held", 32'(match_cnt), 32'd2);
    @(negedge clk);
    chk("tgt2_cnt_still_held", 32'(match_cnt), 32'd2);

    // Illegal lengths
    cfg_bad(0);
    cfg_bad(9);
    cfg_bad(15);

    // Abort after bits 1,0
    load_bits(32'b10, 2);
    run("abort", 8'b101, 3, 1'b1, 8'd0);

    // Abort while armed, with start also asserted: abort wins
    cfg_ok(8'b101, 3, 1'b1, 8'd0);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    chk("armed_abort_busy", 32'(busy), 32'd0);
    chk("armed_abort_state", 32'(dbg_state), 32'(S_IDLE));

    // start in IDLE has no effect
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("idle_start_busy", 32'(busy), 32'd0);
    chk("idle_start_cfg_ready", 32'(cfg_ready), 32'd1);

    // len = 1: every matching bit is a match
    load_bits(32'b1101_1100_1011, 12);
    run("len1", 8'b1, 1, 1'b1, 8'd0);

    // len = MAX_LEN, pattern sent twice with noise in between
    load_bits(32'b1011_0010_0110_1011_0010, 20);
    run("len8", 8'b1011_0010, 8, 1'b0, 8'd0);

    // Counter wrap with target 0
    stim_q.delete();
    for (int i = 0; i < 260; i++) stim_q.push_back(1'b1);
    run("wrap", 8'b1, 1, 1'b1, 8'd0);
    chk("wrap_cnt", 32'(match_cnt), 32'd4);

    // Reset in the middle of a run, right after a match
    cfg_ok(8'b101, 3, 1'b1, 8'd0);
    do_start();
    din = 1'b1; model_bit(1'b1, fin); @(negedge clk);
    din = 1'b0; model_bit(1'b0, fin); @(negedge clk);
    din = 1'b1; model_bit(1'b1, fin);
    @(posedge clk);
    #2;
    R = 1'b0;
    #1;
    chk("midrst_out", 32'(dout), 32'd0);
    chk("midrst_match_cnt", 32'(match_cnt), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("midrst_state", 32'(dbg_state), 32'(S_IDLE));
    exp_q.delete();
    m_cnt = 8'd0;
    @(negedge clk);
    R = 1'b1;
    @(negedge clk);

    // Randomized runs, streams biased towards the pattern
    for (int r = 0; r < 12; r++) begin
      l = $urandom_range(1, MAX_LEN);
      p = 8'($urandom);
      stim_q.delete();
      for (int n = 0; n < 32; n++) begin
        if ($urandom_range(0, 3) != 0) stim_q.push_back(p[l - 1 - (n % l)]);
        else stim_q.push_back(1'($urandom_range(0, 1)));
      end
      run("rand", p, l, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge clk);
    chk("final_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
